// File: rtl/coef_update_sched.sv
// coef_update_sched: validates SPI coefficient frames and swaps them into the filter bank on a sample boundary
module coef_update_sched #(
  parameter logic [15:0] FRAME_HDR = 16'hC0EF,
  parameter logic [15:0] COEF_ONE = 16'h4000,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic clk,
  input logic reset,
  input logic update_en,
  input logic [335:0] frame,
  input logic output_ready,
  output logic [15:0] low_b0,
  output logic [15:0] low_b1,
  output logic [15:0] low_b2,
  output logic [15:0] low_a1,
  output logic [15:0] low_a2,
  output logic [15:0] mid_b0,
  output logic [15:0] mid_b1,
  output logic [15:0] mid_b2,
  output logic [15:0] mid_a1,
  output logic [15:0] mid_a2,
  output logic [15:0] high_b0,
  output logic [15:0] high_b1,
  output logic [15:0] high_b2,
  output logic [15:0] high_a1,
  output logic [15:0] high_a2,
  output logic busy,
  output logic apply_pulse,
  output logic err_hdr,
  output logic err_sum,
  output logic err_unstable,
  output logic bound_timeout,
  output logic [7:0] update_count
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [239:0] COEF_RST = {3{64'h0, COEF_ONE}};
  typedef enum logic [2:0] {IDLE, CAPTURE, CHECK, WAIT_BOUND, APPLY} state_t;
  state_t state, state_nxt;
  logic prev, pending, forced, rise, hdr_ok, last, expire, bad, unstable, unstable_nxt, sum_bad;
  logic [239:0] shadow_coef, coef;
  logic [15:0] shadow_sum, shadow_mask, acc, acc_nxt, word_cur;
  logic [255:0] words;
  logic [3:0] cnt;
  logic [TW-1:0] wcnt;
  logic unused_reserved;
  // words 15-17 are reserved and never looked at
  assign unused_reserved = ^frame[287:240];
  assign rise = update_en & ~prev;
  assign hdr_ok = frame[335:320] == FRAME_HDR;
  assign last = cnt == 4'd15;
  assign expire = wcnt == TW'(TIMEOUT_CYC - 1);
  // check order: coefficient words 0-14, then the mask word in slot 15
  assign words = {shadow_mask, shadow_coef};
  assign word_cur = words[{cnt, 4'b0} +: 16];
  assign acc_nxt = acc ^ word_cur;
  // an a2 outside [-1,1) in Q2.14 has its top two bits disagreeing
  assign bad = (cnt == 4'd4 && shadow_mask[0] || cnt == 4'd9 && shadow_mask[1] || cnt == 4'd14 && shadow_mask[2]) && (word_cur[15] ^ word_cur[14]);
  assign unstable_nxt = unstable | bad;
  assign sum_bad = acc_nxt != shadow_sum;
  assign busy = state != IDLE;
  assign apply_pulse = state == APPLY;
  assign {low_a2, low_a1, low_b2, low_b1, low_b0} = coef[79:0];
  assign {mid_a2, mid_a1, mid_b2, mid_b1, mid_b0} = coef[159:80];
  assign {high_a2, high_a1, high_b2, high_b1, high_b0} = coef[239:160];
  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = (rise | pending) ? CAPTURE : IDLE;
      CAPTURE: state_nxt = hdr_ok ? CHECK : IDLE;
      CHECK: state_nxt = !last ? CHECK : (sum_bad | unstable_nxt) ? IDLE : WAIT_BOUND;
      WAIT_BOUND: state_nxt = (output_ready | expire) ? APPLY : WAIT_BOUND;
      APPLY: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // state register and datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      prev <= 1'b0;
      pending <= 1'b0;
      forced <= 1'b0;
      shadow_coef <= '0;
      shadow_sum <= '0;
      shadow_mask <= '0;
      acc <= '0;
      unstable <= 1'b0;
      cnt <= '0;
      wcnt <= '0;
      coef <= COEF_RST;
      err_hdr <= 1'b0;
      err_sum <= 1'b0;
      err_unstable <= 1'b0;
      bound_timeout <= 1'b0;
      update_count <= '0;
    end else begin
      state <= state_nxt;
      prev <= update_en;
      pending <= (state == IDLE) ? 1'b0 : pending | rise;
      cnt <= (state == CHECK) ? cnt + 4'd1 : '0;
      acc <= (state == CHECK) ? acc_nxt : '0;
      unstable <= (state == CHECK) ? unstable_nxt : 1'b0;
      wcnt <= (state == WAIT_BOUND) ? wcnt + 1'b1 : '0;
      if (state == CAPTURE) begin
        shadow_coef <= frame[239:0];
        shadow_sum <= frame[303:288];
        shadow_mask <= frame[319:304];
        if (!hdr_ok) err_hdr <= 1'b1;
      end
      if (state == CHECK && last) begin
        if (sum_bad) err_sum <= 1'b1;
        else if (unstable_nxt) err_unstable <= 1'b1;
      end
      if (state == WAIT_BOUND && expire && !output_ready) begin
        bound_timeout <= 1'b1;
        forced <= 1'b1;
      end
      if (state == APPLY) begin
        for (int b = 0; b < 3; b++)
          if (shadow_mask[b]) coef[b*80 +: 80] <= shadow_coef[b*80 +: 80];
        err_hdr <= 1'b0;
        err_sum <= 1'b0;
        err_unstable <= 1'b0;
        if (!forced) bound_timeout <= 1'b0;
        forced <= 1'b0;
        update_count <= update_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_coef_update_sched.sv
// tb_coef_update_sched: directed self-checking bench for coef_update_sched
module tb_coef_update_sched;
  logic clk = 1'b0, reset, update_en, output_ready;
  logic [335:0] frame;
  logic [15:0] low_b0, low_b1, low_b2, low_a1, low_a2;
  logic [15:0] mid_b0, mid_b1, mid_b2, mid_a1, mid_a2;
  logic [15:0] high_b0, high_b1, high_b2, high_a1, high_a2;
  logic busy, apply_pulse, err_hdr, err_sum, err_unstable, bound_timeout;
  logic [7:0] update_count;
  int errs = 0, checks = 0;
  logic [15:0] w[21];
  logic [15:0] ec[15];

  coef_update_sched dut (
    .clk(clk), .reset(reset), .update_en(update_en), .frame(frame), .output_ready(output_ready),
    .low_b0(low_b0), .low_b1(low_b1), .low_b2(low_b2), .low_a1(low_a1), .low_a2(low_a2),
    .mid_b0(mid_b0), .mid_b1(mid_b1), .mid_b2(mid_b2), .mid_a1(mid_a1), .mid_a2(mid_a2),
    .high_b0(high_b0), .high_b1(high_b1), .high_b2(high_b2), .high_a1(high_a1), .high_a2(high_a2),
    .busy(busy), .apply_pulse(apply_pulse), .err_hdr(err_hdr), .err_sum(err_sum),
    .err_unstable(err_unstable), .bound_timeout(bound_timeout), .update_count(update_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_coefs(input string tag);
    logic [15:0] d[15];
    d = '{low_b0, low_b1, low_b2, low_a1, low_a2, mid_b0, mid_b1, mid_b2, mid_a1, mid_a2,
          high_b0, high_b1, high_b2, high_a1, high_a2};
    for (int k = 0; k < 15; k++) chk($sformatf("%s_c%0d", tag, k), {16'h0, d[k]}, {16'h0, ec[k]});
  endtask

  task automatic chk_flags(input string tag, input logic h, input logic s, input logic u, input logic t);
    chk({tag, "_hdr"}, {31'h0, err_hdr}, {31'h0, h});
    chk({tag, "_sum"}, {31'h0, err_sum}, {31'h0, s});
    chk({tag, "_unst"}, {31'h0, err_unstable}, {31'h0, u});
    chk({tag, "_tmo"}, {31'h0, bound_timeout}, {31'h0, t});
  endtask

  // fills words 0-20 with a frame whose checksum is correct
  task automatic build(input logic [15:0] base, input logic [2:0] mask);
    for (int k = 0; k < 15; k++) w[k] = base + 16'(k) * 16'h0101;
    w[15] = 16'hDEAD;
    w[16] = 16'hBEEF;
    w[17] = 16'hFFFF;
    w[19] = {13'h0A5, mask};
    w[20] = 16'hC0EF;
    w[18] = w[19];
    for (int k = 0; k < 15; k++) w[18] = w[18] ^ w[k];
  endtask

  task automatic expect_apply();
    for (int b = 0; b < 3; b++)
      if (w[19][b]) for (int c = 0; c < 5; c++) ec[b*5+c] = w[b*5+c];
  endtask

  // drives the frame with a one-cycle update_en pulse; returns at cycle T+1
  task automatic send();
    for (int k = 0; k < 21; k++) frame[k*16 +: 16] = w[k];
    update_en = 1'b1;
    tick();
    update_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    update_en = 1'b0;
    output_ready = 1'b0;
    frame = '0;
    for (int k = 0; k < 15; k++) ec[k] = (k % 5 == 0) ? 16'h4000 : 16'h0000;
    tick(2);
    reset = 1'b0;
    tick();
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_apply", {31'h0, apply_pulse}, 32'h0);
    chk("rst_count", {24'h0, update_count}, 32'h0);
    chk_flags("rst", 0, 0, 0, 0);
    chk_coefs("rst");

    // header error
    build(16'h0100, 3'b111);
    w[20] = 16'h1234;
    send();
    chk("hdr_busy_t1", {31'h0, busy}, 32'h1);
    chk("hdr_flag_t1", {31'h0, err_hdr}, 32'h0);
    tick();
    chk_flags("hdr_t2", 1, 0, 0, 0);
    chk("hdr_busy_t2", {31'h0, busy}, 32'h0);
    tick(3);
    chk_coefs("hdr");

    // valid frame, output_ready 5 cycles into WAIT_BOUND
    build(16'h0100, 3'b111);
    send();
    tick(17);
    chk("v1_wait_busy", {31'h0, busy}, 32'h1);
    tick(5);
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
    chk("v1_apply", {31'h0, apply_pulse}, 32'h1);
    chk_coefs("v1_pre");
    expect_apply();
    tick();
    chk("v1_apply_off", {31'h0, apply_pulse}, 32'h0);
    chk("v1_busy", {31'h0, busy}, 32'h0);
    chk("v1_count", {24'h0, update_count}, 32'h1);
    chk_flags("v1", 0, 0, 0, 0);
    chk_coefs("v1");

    // checksum off by one bit
    build(16'h0200, 3'b111);
    w[18] = w[18] ^ 16'h0001;
    send();
    tick(16);
    chk("sum_t17", {31'h0, err_sum}, 32'h0);
    tick();
    chk_flags("sum_t18", 0, 1, 0, 0);
    chk("sum_busy", {31'h0, busy}, 32'h0);
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
    chk("sum_noapply", {31'h0, apply_pulse}, 32'h0);
    tick(2);
    chk("sum_count", {24'h0, update_count}, 32'h1);
    chk_coefs("sum");

    // valid frame at minimum latency clears err_sum
    build(16'h0300, 3'b111);
    send();
    tick(17);
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
    chk("min_apply_t19", {31'h0, apply_pulse}, 32'h1);
    chk("min_sum_t19", {31'h0, err_sum}, 32'h1);
    expect_apply();
    tick();
    chk_flags("min_t20", 0, 0, 0, 0);
    chk("min_count", {24'h0, update_count}, 32'h2);
    chk_coefs("min");

    // unstable mid a2 with mid enabled
    build(16'h0400, 3'b010);
    w[9] = 16'h4000;
    w[18] = w[19];
    for (int k = 0; k < 15; k++) w[18] = w[18] ^ w[k];
    send();
    tick(17);
    chk_flags("unst", 0, 0, 1, 0);
    chk("unst_busy", {31'h0, busy}, 32'h0);
    tick(2);
    chk("unst_count", {24'h0, update_count}, 32'h2);

    // same a2 but only low band enabled
    w[19] = {13'h0A5, 3'b001};
    w[18] = w[19];
    for (int k = 0; k < 15; k++) w[18] = w[18] ^ w[k];
    send();
    tick(17);
    chk("lowonly_busy", {31'h0, busy}, 32'h1);
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
    chk("lowonly_apply", {31'h0, apply_pulse}, 32'h1);
    expect_apply();
    tick();
    chk_flags("lowonly", 0, 0, 0, 0);
    chk("lowonly_count", {24'h0, update_count}, 32'h3);
    chk_coefs("lowonly");

    // forced apply after TIMEOUT_CYC cycles in WAIT_BOUND
    build(16'h0500, 3'b100);
    send();
    tick(17);
    tick(4095);
    chk("tmo_not_yet", {31'h0, apply_pulse}, 32'h0);
    chk("tmo_flag_early", {31'h0, bound_timeout}, 32'h0);
    tick();
    chk("tmo_apply", {31'h0, apply_pulse}, 32'h1);
    chk("tmo_flag", {31'h0, bound_timeout}, 32'h1);
    expect_apply();
    tick();
    chk("tmo_flag_kept", {31'h0, bound_timeout}, 32'h1);
    chk("tmo_count", {24'h0, update_count}, 32'h4);
    chk_coefs("tmo");

    // second rise during CHECK becomes a pending capture
    build(16'h0600, 3'b111);
    send();
    tick(4);
    build(16'h0700, 3'b011);
    for (int k = 0; k < 21; k++) frame[k*16 +: 16] = w[k];
    update_en = 1'b1;
    tick();
    update_en = 1'b0;
    build(16'h0600, 3'b111);
    tick(12);
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
    chk("pend_apply", {31'h0, apply_pulse}, 32'h1);
    expect_apply();
    tick();
    chk("pend_idle", {31'h0, busy}, 32'h0);
    chk("pend_count1", {24'h0, update_count}, 32'h5);
    chk("pend_tmo_clr", {31'h0, bound_timeout}, 32'h0);
    chk_coefs("pend_a");
    tick();
    chk("pend_capture", {31'h0, busy}, 32'h1);
    build(16'h0700, 3'b011);
    tick(17);
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
    chk("pend_apply2", {31'h0, apply_pulse}, 32'h1);
    expect_apply();
    tick();
    chk("pend_count2", {24'h0, update_count}, 32'h6);
    chk_coefs("pend_b");

    // reset while waiting for a sample boundary
    build(16'h0800, 3'b111);
    send();
    tick(17);
    chk("rstw_busy_pre", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 15; k++) ec[k] = (k % 5 == 0) ? 16'h4000 : 16'h0000;
    chk("rstw_busy", {31'h0, busy}, 32'h0);
    chk("rstw_count", {24'h0, update_count}, 32'h0);
    chk_coefs("rstw");
    tick();
    reset = 1'b0;
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
    chk("rstw_noapply", {31'h0, apply_pulse}, 32'h0);
    chk("rstw_idle", {31'h0, busy}, 32'h0);
    chk_flags("rstw", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/coef_update_sched.md
# coef_update_sched

Sequences coefficient updates from the SPI capture path into the three-band biquad filter bank. On each new SPI frame it captures the frame and checks its header, checksum and per-band stability. It then waits for an audio sample boundary and swaps the accepted coefficients into the active registers in one cycle. Filters therefore never see a torn or invalid coefficient set. It sits between the SPI clock-domain-crossing logic and the filter bank, in the system clock domain.

## Interface

- FRAME_HDR, 16'hC0EF: required value of frame word 20.
- COEF_ONE, 16'h4000: Q2.14 unity; reset value of every b0.
- TIMEOUT_CYC, 4096: maximum WAIT_BOUND cycles before a forced apply.
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- update_en  in  1  synchronized SPI valid level; only its rising edge is used.
- frame  in  336  latched SPI frame; valid from the cycle after the update_en rising edge.
- output_ready  in  1  one-cycle sample-boundary strobe from the audio output path.
- {low,mid,high}_{b0,b1,b2,a1,a2}  out  16 each (15 ports), signed Q2.14  active coefficients.
- busy  out  1  high in every state except IDLE.
- apply_pulse  out  1  high for exactly the APPLY cycle.
- err_hdr, err_sum, err_unstable  out  1 each  sticky error flags; all cleared by the next APPLY.
- bound_timeout  out  1  sticky; set by a forced apply, cleared by the next normal apply.
- update_count  out  8  count of APPLY cycles; wraps 255 -> 0.

## Operation

- Frame layout: word k is frame[16k+15:16k].
  - Words 0-14 are coefficients at index band*5+c, with band low=0, mid=1, high=2 and c ordered b0, b1, b2, a1, a2.
  - Words 15-17 are reserved and ignored.
  - Word 18 is the checksum.
  - Word 19 is the band mask; bit 0 = low, bit 1 = mid, bit 2 = high; bits 15:3 are ignored.
  - Word 20 is the header.
- Edge detect: a registered copy of update_en; rise = update_en & ~prev.
- State machine:
  - IDLE: on rise, go to CAPTURE.
  - CAPTURE: copy words 0-20 into a shadow register. If word 20 != FRAME_HDR, set err_hdr and go to IDLE; otherwise go to CHECK.
  - CHECK: runs 16 cycles with a 4-bit counter. It XOR-accumulates words 0-14, then word 19. Each cycle it tests one word; for a2 words of enabled bands, shadow bits [15:14] must be 00 or 11.
    - On the last cycle (result includes the last word): if accumulator != word 18, set err_sum and go to IDLE.
    - Else, if any stability test failed, set err_unstable and go to IDLE.
    - Else go to WAIT_BOUND.
  - WAIT_BOUND: a cycle counter starts at 0.
    - output_ready=1: go to APPLY.
    - Otherwise, when the counter reaches TIMEOUT_CYC-1: set bound_timeout and go to APPLY.
    - output_ready and expiry in the same cycle: normal apply, no flag.
  - APPLY: load each band whose mask bit is set from the shadow; other bands hold their values. Clear err_* flags, increment update_count, then go to IDLE. bound_timeout is cleared only if this apply was not forced.
- Mask = 0 is a valid frame: APPLY still occurs, but no coefficient changes.
- Pending update:
  - A rise seen in CAPTURE, CHECK, WAIT_BOUND or APPLY sets a single pending bit; multiple rises merge.
  - When returning to IDLE after APPLY or an error, a set pending bit sends the machine straight to CAPTURE on the next cycle and clears the bit. It samples the frame current at that time.
  - A rise in the IDLE cycle itself starts capture normally.
- output_ready is ignored outside WAIT_BOUND.

## Timing

- Reset values:
  - All b0 = COEF_ONE; all other coefficients = 0 (passthrough).
  - State IDLE; pending, busy, apply_pulse, all error flags, bound_timeout = 0.
  - update_count = 0; edge-detect register = 0.
- Reset mid-operation: immediate return to the reset values above. Any in-flight frame is discarded.
- Rise sampled at cycle T: CAPTURE at T+1, CHECK at T+2..T+17, WAIT_BOUND from T+18.
- Minimum latency: output_ready high at T+18 gives APPLY at T+19. New coefficients are visible from T+20.
- Coefficient outputs are registered and change only at the end of an APPLY cycle.
- Error flags are registered at the end of the failing state's cycle:
  - Header error visible at T+2.
  - Checksum or stability error visible at T+18.
- busy is high from T+1 through the APPLY cycle or the failing cycle inclusive.

## Test plan

- Reset, then valid frame with mask=3'b111 and distinct coefficients; output_ready pulsed 5 cycles into WAIT_BOUND -> all 15 outputs match the frame one cycle after apply_pulse; update_count=1; no flags.
- Frame with header 16'h1234 -> err_hdr=1 at T+2; coefficients stay at passthrough; busy drops after CAPTURE.
- Checksum word off by one bit -> err_sum=1; no apply. Then a valid frame -> apply_pulse; err_sum cleared.
- Mid-band a2=16'h4000 with mask=3'b010 -> err_unstable=1. Same a2 with mask=3'b001 -> accepted; only low band changes.
- No output_ready after CHECK -> forced apply exactly TIMEOUT_CYC cycles into WAIT_BOUND; bound_timeout=1.
- Second rise during CHECK -> first frame applied, then CAPTURE on the next cycle; update_count=2. Separately, reset asserted in WAIT_BOUND -> passthrough and IDLE.
